// File: rtl/present_sbox_keyadd_redundant_pkg.sv
// PRESENT S-box table, FSM states and a width-generic S-box layer helper.
// Shared by the redundant S-box/key-add datapath and its interface.
package present_pkg;

    localparam int MAX_NIBBLES = 16;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        OUTPUT
    } fsm_e;

    // Unused upper nibbles pass through the S-box harmlessly; callers slice.
    function automatic logic [4*MAX_NIBBLES-1:0] sbox_layer(
        input logic [4*MAX_NIBBLES-1:0] x
    );
        logic [4*MAX_NIBBLES-1:0] y;
        y = '0;
        for (int i = 0; i < MAX_NIBBLES; i++) begin
            y[4*i+:4] = SBOX[x[4*i+:4]];
        end
        return y;
    endfunction

endpackage

// File: rtl/present_sbox_keyadd_redundant_if.sv
// Operand/result handshake bundle for the redundant S-box/key-add layer.
// master = operand producer and result consumer, slave = the datapath.
interface present_sbox_keyadd_redundant_if #(
    parameter int NIBBLES = 3,
    parameter int FCW     = 8
);
    import present_pkg::*;

    localparam int W = 4 * NIBBLES;

    logic           io_in_valid;
    logic           io_in_ready;
    logic [W-1:0]   io_state;
    logic [W-1:0]   io_key;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out;
    logic           io_fault;
    logic [FCW-1:0] io_fault_count;

    modport master (
        output io_in_valid, io_state, io_key, io_out_ready,
        input  io_in_ready, io_out_valid, io_out, io_fault, io_fault_count
    );

    modport slave (
        input  io_in_valid, io_state, io_key, io_out_ready,
        output io_in_ready, io_out_valid, io_out, io_fault, io_fault_count
    );

endinterface

// File: rtl/present_sbox_keyadd_redundant_sbox4.sv
// Combinational 4-bit PRESENT S-box lane.
// One instance per nibble of the datapath.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);

    assign y = SBOX[x];

endmodule

// File: rtl/present_sbox_keyadd_redundant.sv
// PRESENT S-box + key-add layer with temporal redundancy: each operation is
// recomputed REPEATS times from captured registers and compared.
module present_sbox_keyadd_redundant
    import present_pkg::*;
#(
    parameter int NIBBLES = 3,
    parameter int REPEATS = 2,
    parameter int FCW     = 8
) (
    input logic clock,
    input logic reset,
    present_sbox_keyadd_redundant_if.slave io
);

    localparam int W  = 4 * NIBBLES;
    localparam int PW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam logic [PW-1:0] LAST = PW'(REPEATS - 1);

    fsm_e           fsm_q;
    logic [W-1:0]   state_q;
    logic [W-1:0]   key_q;
    logic [W-1:0]   ref_q;
    logic [W-1:0]   out_q;
    logic [PW-1:0]  pass_q;
    logic           mismatch_q;
    logic           fault_q;
    logic [FCW-1:0] cnt_q;

    logic [W-1:0]   sb;
    logic [W-1:0]   r;
    logic           diff;
    logic           fault_d;
    logic           last;

    for (genvar i = 0; i < NIBBLES; i++) begin : g_lane
        present_sbox4 u_sbox (
            .x (state_q[4*i+:4]),
            .y (sb[4*i+:4])
        );
    end

    assign r       = sb ^ key_q;
    // Pass 0 only seeds the reference; later passes are the checks.
    assign diff    = (pass_q != '0) && (r != ref_q);
    assign fault_d = mismatch_q | diff;
    assign last    = (pass_q == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            key_q      <= '0;
            ref_q      <= '0;
            out_q      <= '0;
            pass_q     <= '0;
            mismatch_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (io.io_in_valid) begin
                        state_q    <= io.io_state;
                        key_q      <= io.io_key;
                        mismatch_q <= 1'b0;
                        pass_q     <= '0;
                        fsm_q      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (pass_q == '0) ref_q <= r;
                    if (diff) mismatch_q <= 1'b1;
                    if (last) begin
                        out_q   <= fault_d ? '0 : r;
                        fault_q <= fault_d;
                        if (fault_d && (cnt_q != '1)) begin
                            cnt_q <= cnt_q + FCW'(1);
                        end
                        fsm_q <= OUTPUT;
                    end else begin
                        pass_q <= pass_q + PW'(1);
                    end
                end
                OUTPUT: begin
                    if (io.io_out_ready) fsm_q <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign io.io_in_ready    = (fsm_q == IDLE);
    assign io.io_out_valid   = (fsm_q == OUTPUT);
    assign io.io_out         = out_q;
    assign io.io_fault       = fault_q;
    assign io.io_fault_count = cnt_q;

endmodule

// File: tb/tb_present_sbox_keyadd_redundant.sv
// Scoreboard bench for the redundant PRESENT S-box/key-add layer.
// A second instance with a 2-bit fault counter exercises saturation.
module tb_present_sbox_keyadd_redundant;

    localparam int N = 3;
    localparam int R = 2;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] out;
        logic         fault;
        int           cnt;
        int           cnt2;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    present_sbox_keyadd_redundant_if #(.NIBBLES(N), .FCW(8)) io ();
    present_sbox_keyadd_redundant_if #(.NIBBLES(N), .FCW(2)) io2 ();

    present_sbox_keyadd_redundant #(
        .NIBBLES(N), .REPEATS(R), .FCW(8)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    present_sbox_keyadd_redundant #(
        .NIBBLES(N), .REPEATS(R), .FCW(2)
    ) u_dut2 (
        .clock (clock),
        .reset (reset),
        .io    (io2.slave)
    );

    assign io2.io_in_valid  = io.io_in_valid;
    assign io2.io_state     = io.io_state;
    assign io2.io_key       = io.io_key;
    assign io2.io_out_ready = io.io_out_ready;

    exp_t sb_q[$];
    int compared   = 0;
    int mismatched = 0;
    int fc  = 0;
    int fc2 = 0;
    int sbox_tab[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [W-1:0] fv;
    logic [W-1:0] fv2;
    logic seen = 1'b0;

    function automatic logic [W-1:0] model(input logic [W-1:0] s,
                                           input logic [W-1:0] k);
        logic [W-1:0] y;
        int n;
        y = '0;
        for (int i = 0; i < N; i++) begin
            n = int'(s[4*i+:4]);
            y[4*i+:4] = 4'(sbox_tab[n]) ^ k[4*i+:4];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset || !io.io_out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got %0h expected none",
                         io.io_out);
            end else begin
                e = sb_q.pop_front();
                chk("out", 64'(io.io_out), 64'(e.out));
                chk("fault", 64'(io.io_fault), 64'(e.fault));
                chk("count", 64'(io.io_fault_count), 64'(e.cnt));
                chk("out_fcw2", 64'(io2.io_out), 64'(e.out));
                chk("count_fcw2", 64'(io2.io_fault_count), 64'(e.cnt2));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!io.io_in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!io.io_in_ready) chk("ready_timeout", 64'(0), 64'(1));
    endtask

    // Returns #1 after the accept edge, or after the pass-1 edge if injecting.
    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] k,
                         input bit inject, input bit push);
        exp_t e;
        @(negedge clock);
        wait_ready();
        io.io_in_valid = 1'b1;
        io.io_state    = s;
        io.io_key      = k;
        @(posedge clock);
        #1;
        io.io_in_valid = 1'b0;
        if (push) begin
            if (inject) begin
                if (fc < 255) fc++;
                if (fc2 < 3) fc2++;
            end
            e.out   = inject ? '0 : model(s, k);
            e.fault = inject;
            e.cnt   = fc;
            e.cnt2  = fc2;
            sb_q.push_back(e);
        end
        if (inject) begin
            @(posedge clock);
            #1;
            fv  = u_dut.state_q ^ W'(1);
            fv2 = u_dut2.state_q ^ W'(1);
            force u_dut.state_q  = fv;
            force u_dut2.state_q = fv2;
            @(posedge clock);
            #1;
            release u_dut.state_q;
            release u_dut2.state_q;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(io.io_in_ready), 64'(1));
        chk({tag, "_out_valid"}, 64'(io.io_out_valid), 64'(0));
        chk({tag, "_out"}, 64'(io.io_out), 64'(0));
        chk({tag, "_fault"}, 64'(io.io_fault), 64'(0));
        chk({tag, "_count"}, 64'(io.io_fault_count), 64'(0));
    endtask

    initial begin
        logic [W-1:0] s;
        logic [W-1:0] k;
        int n;
        io.io_in_valid  = 1'b0;
        io.io_state     = '0;
        io.io_key       = '0;
        io.io_out_ready = 1'b1;

        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Latency: valid only after the second edge following accept.
        issue(12'h000, 12'h000, 1'b0, 1'b1);
        chk("lat_t0", 64'(io.io_out_valid), 64'(0));
        @(posedge clock);
        #1;
        chk("lat_t1", 64'(io.io_out_valid), 64'(0));
        @(posedge clock);
        #1;
        chk("lat_t2", 64'(io.io_out_valid), 64'(1));

        issue(12'h123, 12'hFFF, 1'b0, 1'b1);
        issue(12'hFED, 12'h000, 1'b0, 1'b1);

        issue(12'h123, 12'h000, 1'b1, 1'b1);
        issue(12'h456, 12'h789, 1'b0, 1'b1);

        // Reset during COMPUTE pass 0 discards the op.
        @(negedge clock);
        wait_ready();
        issue(12'h5A5, 12'h0F0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        fc  = 0;
        fc2 = 0;
        @(negedge clock);
        reset = 1'b0;
        issue(12'h000, 12'h000, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            issue(W'($urandom), W'($urandom), 1'b1, 1'b1);
        end

        // Back-pressure with ignored in_valid pulses.
        @(negedge clock);
        wait_ready();
        io.io_out_ready = 1'b0;
        s = 12'hA3C;
        k = 12'h5E1;
        issue(s, k, 1'b0, 1'b1);
        n = 0;
        while (!io.io_out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_out", 64'(io.io_out), 64'(model(s, k)));
            chk("stall_fault", 64'(io.io_fault), 64'(0));
            chk("stall_valid", 64'(io.io_out_valid), 64'(1));
            chk("stall_in_ready", 64'(io.io_in_ready), 64'(0));
            io.io_in_valid = (i % 2 == 0);
            io.io_state    = W'($urandom);
            io.io_key      = W'($urandom);
        end
        @(negedge clock);
        io.io_in_valid  = 1'b0;
        io.io_out_ready = 1'b1;

        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom),
                  ($urandom_range(0, 3) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'(0));
        repeat (4) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
